// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types.
// Contents:
//   lc3b_word      - 16-bit machine word
//   lc3b_line      - 128-bit cache/memory line
//   lc3b_line_addr - 12-bit line address (byte address [15:4])
//   lc3b_line_sel  - 16-bit byte-lane select, one bit per line byte
//   sel_to_mask    - expands a byte-lane select into a 128-bit bit mask
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;
    typedef logic [11:0]  lc3b_line_addr;
    typedef logic [15:0]  lc3b_line_sel;

    // Byte lane i of the select covers bits [8i+7:8i] of the line.
    function automatic lc3b_line sel_to_mask(input lc3b_line_sel sel);
        lc3b_line mask;
        mask = 128'd0;
        for (int i = 0; i < 16; i++) begin
            mask[8*i +: 8] = sel[i] ? 8'hFF : 8'h00;
        end
        return mask;
    endfunction

endpackage

// File: rtl/line_ram.sv
// Synchronous single-port line store, DEPTH_LINES x 128 bits.
// Ports:
//   clk, rst - clock; asynchronous active-high reset (read register only)
//   wr_en    - write strobe; only lanes with sel[i] set are updated
//   rd_en    - read strobe; rdata is loaded on the same edge
//   addr     - line index
//   sel      - byte-lane enables for writes
//   wdata    - write line
//   rdata    - registered read line, holds between reads
module line_ram
    import lc3b_types::*;
#(
    parameter int DEPTH_LINES = 256,
    parameter int AW          = $clog2(DEPTH_LINES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          rd_en,
    input  logic [AW-1:0] addr,
    input  lc3b_line_sel  sel,
    input  lc3b_line      wdata,
    output lc3b_line      rdata
);

    lc3b_line mem_r [DEPTH_LINES];
    lc3b_line mask_s;

    // Expand the lane select to a bit mask for the merge.
    always_comb begin
        mask_s = sel_to_mask(sel);
    end

    // Line storage; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[addr] <= (mem_r[addr] & ~mask_s) | (wdata & mask_s);
        end
    end

    // Read register; only a read updates it, so it holds across writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= 128'd0;
        end else if (rd_en) begin
            rdata <= mem_r[addr];
        end
    end

endmodule

// File: rtl/wb_line_responder.sv
// Wishbone line slave used as backing store for ifetch/memory masters.
// Accepts one request at a time, waits LATENCY cycles, commits byte-lane
// writes or loads the read line, and pulses ACK for one cycle.
// Ports:
//   clk, rst      - clock; asynchronous active-high reset
//   CYC, STB, WE  - Wishbone cycle, strobe, write-enable
//   ADR           - line address (only ADR mod DEPTH_LINES is used)
//   SEL           - byte-lane enables for writes
//   DAT_M / DAT_S - write line in / registered read line out
//   ACK           - registered single-cycle transfer-complete pulse
//   read_count    - completed reads, wrapping
//   write_count   - completed writes, wrapping
module wb_line_responder
    import lc3b_types::*;
#(
    parameter int LATENCY     = 4,
    parameter int DEPTH_LINES = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          CYC,
    input  logic          STB,
    input  logic          WE,
    input  lc3b_line_addr ADR,
    input  lc3b_line_sel  SEL,
    input  lc3b_line      DAT_M,
    output lc3b_line      DAT_S,
    output logic          ACK,
    output logic [15:0]   read_count,
    output logic [15:0]   write_count
);

    localparam int AW     = $clog2(DEPTH_LINES);
    localparam int WAIT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(LATENCY);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } wb_resp_state_t;

    wb_resp_state_t state_r, state_nx_s;
    logic [WAIT_W-1:0] wait_r;
    lc3b_line_addr     adr_r;
    lc3b_line_sel      sel_r;
    lc3b_line          dat_r;
    logic              we_r;
    logic              ack_r;
    logic [15:0]       read_count_r, write_count_r;

    logic              req_s;
    logic              enter_resp_s;
    logic              ack_nx_s;
    logic              eff_we_s;
    lc3b_line_addr     eff_adr_s;
    lc3b_line_sel      eff_sel_s;
    lc3b_line          eff_dat_s;
    logic              wr_en_s, rd_en_s;

    assign req_s = CYC & STB;

    // State register plus the registered ACK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            ack_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            ack_r   <= ack_nx_s;
        end
    end

    // Next-state logic; an abort check precedes the wait-count check.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    if (LATENCY == 0) begin
                        state_nx_s = ST_RESP;
                    end else begin
                        state_nx_s = ST_BUSY;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!req_s) begin
                    state_nx_s = ST_IDLE;
                end else if (wait_r == WAIT_ONE) begin
                    state_nx_s = ST_RESP;
                end else begin
                    state_nx_s = ST_BUSY;
                end
            end
            ST_RESP: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Output decode: the edge entering RESP commits and raises ACK.
    always_comb begin
        enter_resp_s = 1'b0;
        ack_nx_s     = 1'b0;
        if (state_nx_s == ST_RESP) begin
            enter_resp_s = 1'b1;
            ack_nx_s     = 1'b1;
        end else begin
            enter_resp_s = 1'b0;
            ack_nx_s     = 1'b0;
        end
    end

    // With zero latency the commit happens on the capture edge itself,
    // so the live bus is used in IDLE and the captured copy afterwards.
    always_comb begin
        eff_we_s  = we_r;
        eff_adr_s = adr_r;
        eff_sel_s = sel_r;
        eff_dat_s = dat_r;
        if (state_r == ST_IDLE) begin
            eff_we_s  = WE;
            eff_adr_s = ADR;
            eff_sel_s = SEL;
            eff_dat_s = DAT_M;
        end else begin
            eff_we_s  = we_r;
            eff_adr_s = adr_r;
            eff_sel_s = sel_r;
            eff_dat_s = dat_r;
        end
    end

    assign wr_en_s = enter_resp_s & eff_we_s;
    assign rd_en_s = enter_resp_s & ~eff_we_s;

    // Request capture; bus changes after acceptance are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adr_r <= 12'd0;
            sel_r <= 16'd0;
            dat_r <= 128'd0;
            we_r  <= 1'b0;
        end else if ((state_r == ST_IDLE) && req_s) begin
            adr_r <= ADR;
            sel_r <= SEL;
            dat_r <= DAT_M;
            we_r  <= WE;
        end
    end

    // Wait-state counter: loaded on capture, counts down while BUSY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_r <= {WAIT_W{1'b0}};
        end else if ((state_r == ST_IDLE) && req_s) begin
            wait_r <= WAIT_LOAD;
        end else if (state_r == ST_BUSY) begin
            wait_r <= wait_r - WAIT_ONE;
        end
    end

    // Transfer counters, stepped on the edge entering RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_count_r  <= 16'd0;
            write_count_r <= 16'd0;
        end else begin
            if (rd_en_s) begin
                read_count_r <= read_count_r + 16'd1;
            end
            if (wr_en_s) begin
                write_count_r <= write_count_r + 16'd1;
            end
        end
    end

    line_ram #(
        .DEPTH_LINES(DEPTH_LINES)
    ) u_line_ram (
        .clk  (clk),
        .rst  (rst),
        .wr_en(wr_en_s),
        .rd_en(rd_en_s),
        .addr (eff_adr_s[AW-1:0]),
        .sel  (eff_sel_s),
        .wdata(eff_dat_s),
        .rdata(DAT_S)
    );

    assign ACK         = ack_r;
    assign read_count  = read_count_r;
    assign write_count = write_count_r;

endmodule

// File: tb/tb_wb_line_responder.sv
// Scoreboard bench: dut_a (LATENCY=4) runs directed and random traffic,
// dut_b (LATENCY=0) runs the held-strobe burst.
module tb_wb_line_responder;
    import lc3b_types::*;

    localparam int LAT_A = 4;
    localparam int LAT_B = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic a_cyc, a_stb, a_we, a_ack;
    logic [11:0] a_adr;
    logic [15:0] a_sel, a_rc, a_wc;
    logic [127:0] a_dm, a_ds;

    logic b_cyc, b_stb, b_we, b_ack;
    logic [11:0] b_adr;
    logic [15:0] b_sel, b_rc, b_wc;
    logic [127:0] b_dm, b_ds;

    wb_line_responder #(.LATENCY(LAT_A), .DEPTH_LINES(256)) dut_a (
        .clk(clk), .rst(rst), .CYC(a_cyc), .STB(a_stb), .WE(a_we), .ADR(a_adr),
        .SEL(a_sel), .DAT_M(a_dm), .DAT_S(a_ds), .ACK(a_ack),
        .read_count(a_rc), .write_count(a_wc));

    wb_line_responder #(.LATENCY(LAT_B), .DEPTH_LINES(256)) dut_b (
        .clk(clk), .rst(rst), .CYC(b_cyc), .STB(b_stb), .WE(b_we), .ADR(b_adr),
        .SEL(b_sel), .DAT_M(b_dm), .DAT_S(b_ds), .ACK(b_ack),
        .read_count(b_rc), .write_count(b_wc));

    typedef struct {
        bit           is_rd;
        logic [127:0] data;
        logic [15:0]  rc;
        logic [15:0]  wc;
        int unsigned  at;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    // Reference model: one line array and transfer counts per DUT.
    logic [127:0] mdl_a [256];
    logic [127:0] mdl_b [256];
    bit           wr_a  [256];
    logic [15:0]  mrc_a, mwc_a, mrc_b, mwc_b;

    int total = 0;
    int bad   = 0;
    int unsigned cyc = 0;
    logic b_ack_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] nw, input logic [15:0] sel);
        logic [127:0] r;
        r = old;
        for (int i = 0; i < 16; i++) begin
            if (sel[i]) r[8*i +: 8] = nw[8*i +: 8];
        end
        return r;
    endfunction

    // Monitor for dut_a: every ACK must match the oldest expectation.
    always @(negedge clk) begin
        if (a_ack === 1'b1) begin
            if (qa.size() == 0) begin
                check("a_spurious_ack", 128'(a_ack), 128'd0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                check("a_ack_cycle", 128'(cyc), 128'(e.at));
                if (e.is_rd) check("a_read_data", a_ds, e.data);
                check("a_read_count", 128'(a_rc), 128'(e.rc));
                check("a_write_count", 128'(a_wc), 128'(e.wc));
            end
        end
    end

    // Monitor for dut_b, including the no-back-to-back-ACK rule.
    always @(negedge clk) begin
        if (b_ack === 1'b1) begin
            check("b_ack_not_consecutive", 128'(b_ack_prev), 128'd0);
            if (qb.size() == 0) begin
                check("b_spurious_ack", 128'(b_ack), 128'd0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                check("b_ack_cycle", 128'(cyc), 128'(e.at));
                if (e.is_rd) check("b_read_data", b_ds, e.data);
                check("b_read_count", 128'(b_rc), 128'(e.rc));
                check("b_write_count", 128'(b_wc), 128'(e.wc));
            end
        end
        b_ack_prev <= b_ack;
    end

    // Push the model's expectation for one dut_a transfer captured at cap.
    task automatic a_expect(input bit we, input logic [11:0] adr, input logic [15:0] sel,
                            input logic [127:0] d, input int unsigned cap);
        exp_t e;
        int idx;
        idx = int'(adr) % 256;
        if (we) begin
            mdl_a[idx] = merge(mdl_a[idx], d, sel);
            wr_a[idx]  = 1'b1;
            mwc_a      = mwc_a + 16'd1;
        end else begin
            mrc_a = mrc_a + 16'd1;
        end
        e.is_rd = !we;
        e.data  = mdl_a[idx];
        e.rc    = mrc_a;
        e.wc    = mwc_a;
        e.at    = cap + LAT_A;
        qa.push_back(e);
    endtask

    task automatic a_xfer(input bit we, input logic [11:0] adr, input logic [15:0] sel, input logic [127:0] d);
        bit seen;
        @(negedge clk);
        a_cyc = 1'b1; a_stb = 1'b1; a_we = we; a_adr = adr; a_sel = sel; a_dm = d;
        a_expect(we, adr, sel, d, cyc + 1);
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (a_ack === 1'b1) begin
                seen = 1'b1;
            end else begin
                // The request is already captured; the bus is now noise.
                a_we  = $urandom_range(0, 1) != 0;
                a_adr = 12'($urandom);
                a_sel = 16'($urandom);
                a_dm  = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        if (!seen) check("a_ack_timeout", 128'(a_ack), 128'd1);
        a_cyc = 1'b0; a_stb = 1'b0;
    endtask

    task automatic b_write(input logic [11:0] adr, input logic [127:0] d);
        exp_t e;
        bit seen;
        @(negedge clk);
        b_cyc = 1'b1; b_stb = 1'b1; b_we = 1'b1; b_adr = adr; b_sel = 16'hFFFF; b_dm = d;
        mdl_b[int'(adr) % 256] = d;
        mwc_b = mwc_b + 16'd1;
        e.is_rd = 1'b0; e.data = d; e.rc = mrc_b; e.wc = mwc_b; e.at = cyc + 1 + LAT_B;
        qb.push_back(e);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (b_ack === 1'b1) seen = 1'b1;
        end
        if (!seen) check("b_ack_timeout", 128'(b_ack), 128'd1);
        b_cyc = 1'b0; b_stb = 1'b0;
    endtask

    initial begin
        logic [127:0] pat;
        bit           seen;
        int           idx;
        exp_t         e;

        rst = 1'b1;
        a_cyc = 1'b0; a_stb = 1'b0; a_we = 1'b0; a_adr = 12'd0; a_sel = 16'd0; a_dm = 128'd0;
        b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0; b_adr = 12'd0; b_sel = 16'd0; b_dm = 128'd0;
        mrc_a = 16'd0; mwc_a = 16'd0; mrc_b = 16'd0; mwc_b = 16'd0;
        for (int i = 0; i < 256; i++) wr_a[i] = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_ack", 128'(a_ack), 128'd0);
        check("reset_dat_s", a_ds, 128'd0);
        check("reset_read_count", 128'(a_rc), 128'd0);
        check("reset_write_count", 128'(a_wc), 128'd0);
        rst = 1'b0;

        // Read latency and basic write/read.
        pat = 128'h0123456789ABCDEF0123456789ABCDEF;
        a_xfer(1'b1, 12'h010, 16'hFFFF, pat);
        a_xfer(1'b0, 12'h010, 16'h0000, 128'd0);

        // Partial write: only the low two lanes may change.
        a_xfer(1'b1, 12'h010, 16'h0003, {112'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A, 16'hBEEF});
        a_xfer(1'b0, 12'h010, 16'h0000, 128'd0);

        // SEL = 0 write is acknowledged and counted but changes nothing.
        a_xfer(1'b1, 12'h010, 16'h0000, {4{32'hFFFFFFFF}});
        a_xfer(1'b0, 12'h010, 16'h0000, 128'd0);

        // Abort: drop STB two edges into a write to 12'h020.
        a_xfer(1'b1, 12'h020, 16'hFFFF, 128'hCAFEF00D_11223344_55667788_99AABBCC);
        @(negedge clk);
        a_cyc = 1'b1; a_stb = 1'b1; a_we = 1'b1; a_adr = 12'h020; a_sel = 16'hFFFF;
        a_dm = 128'hDEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD;
        @(negedge clk);
        @(negedge clk);
        a_stb = 1'b0; a_cyc = 1'b0;
        repeat (8) @(negedge clk);
        a_xfer(1'b0, 12'h020, 16'h0000, 128'd0);

        // Address wrap: 12'h105 aliases line 12'h005.
        a_xfer(1'b1, 12'h105, 16'hFFFF, 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0);
        a_xfer(1'b0, 12'h005, 16'h0000, 128'd0);

        // Randomized traffic against the model.
        for (int t = 0; t < 40; t++) begin
            idx = $urandom_range(0, 255);
            if (!wr_a[idx] || $urandom_range(0, 1) == 0) begin
                a_xfer(1'b1, {4'($urandom), 8'(idx)}, wr_a[idx] ? 16'($urandom) : 16'hFFFF,
                       {$urandom, $urandom, $urandom, $urandom});
            end else begin
                a_xfer(1'b0, {4'($urandom), 8'(idx)}, 16'($urandom), 128'd0);
            end
        end

        // Held strobe on the zero-latency instance: lines 0,1,2 back to back.
        b_write(12'h000, 128'h00000000_00000000_00000000_AAAA0000);
        b_write(12'h001, 128'h11111111_22222222_33333333_44444444);
        b_write(12'h002, 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000);
        @(negedge clk);
        b_cyc = 1'b1; b_stb = 1'b1; b_we = 1'b0; b_adr = 12'h000; b_sel = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            mrc_b = mrc_b + 16'd1;
            e.is_rd = 1'b1; e.data = mdl_b[k]; e.rc = mrc_b; e.wc = mwc_b;
            e.at = (k == 0) ? cyc + 1 : cyc + 2;
            qb.push_back(e);
            seen = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin
                @(negedge clk);
                if (b_ack === 1'b1) seen = 1'b1;
            end
            if (!seen) check("b_held_timeout", 128'(b_ack), 128'd1);
            b_adr = 12'(k + 1);
        end
        @(negedge clk);
        check("b_held_ack_low_after_pulse", 128'(b_ack), 128'd0);
        b_cyc = 1'b0; b_stb = 1'b0;
        check("b_held_read_count", 128'(b_rc), 128'd3);

        // Reset mid-transfer: write captured, then rst while BUSY.
        a_xfer(1'b0, 12'h020, 16'h0000, 128'd0);
        @(negedge clk);
        a_cyc = 1'b1; a_stb = 1'b1; a_we = 1'b1; a_adr = 12'h020; a_sel = 16'hFFFF;
        a_dm = 128'h77777777_77777777_77777777_77777777;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_ack", 128'(a_ack), 128'd0);
        check("rst_mid_dat_s", a_ds, 128'd0);
        check("rst_mid_read_count", 128'(a_rc), 128'd0);
        check("rst_mid_write_count", 128'(a_wc), 128'd0);
        mrc_a = 16'd0; mwc_a = 16'd0; mrc_b = 16'd0; mwc_b = 16'd0;
        @(negedge clk);
        rst = 1'b0;
        a_cyc = 1'b0; a_stb = 1'b0;
        a_xfer(1'b0, 12'h020, 16'h0000, 128'd0);
        a_xfer(1'b1, 12'h030, 16'hFFFF, 128'h13579BDF_2468ACE0_FEDCBA98_76543210);
        a_xfer(1'b0, 12'h030, 16'h0000, 128'd0);

        repeat (4) @(negedge clk);
        check("a_queue_drained", 128'(qa.size()), 128'd0);
        check("b_queue_drained", 128'(qb.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
